ovp_fault_ctrl: RTL
===================

# ovp_fault_ctrl

Synchronous, parametrised successor of the OVP fault latch for the PXD over-voltage protection CPLD. It filters and latches NCH active-low fault inputs and applies a per-channel mask. It records the first channel to trip and drives the shutdown/SSR-off request. It also provides a serial status/control port (ax_* lines from the auxiliary Xilinx), oversampled in the single system clock domain instead of being clocked by ax_clk.

## Interface
- NCH, 24: number of fault channels, 2..30.
- FLT_CYC, 4: consecutive low samples required before a fault latches, 1..15.
- ID_W, $clog2(NCH): width of channel index (derived, not overridden).
- CW, NCH+2: control word length (derived).

Ports (clock and reset first):
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flt_n  in  NCH  raw active-low fault inputs, asynchronous.
- shdn_n  in  1  active-low clear request, effective only in normal mode.
- eng_mode  in  1  high = engineering mode: stat_ok forced 1, trip suppressed.
- arm  in  1  high enables trip output.
- sel  in  ID_W  readout mux select.
- mux_out  out  1  chan_ok[sel]; 0 if sel >= NCH.
- chan_ok  out  NCH  latched per-channel status, 1 = OK.
- stat_ok  out  1  &chan_ok | eng_mode.
- trip  out  1  shutdown request (drives genbart shutdown / SSR off).
- first_id  out  ID_W  index of first latched fault.
- first_vld  out  1  first_id valid.
- ax_clk, ax_frame, ax_write, ax_data_in  in  1 each  serial port, asynchronous.
- ax_data  out  1  serial read data.

## Operation
- Every asynchronous input (flt_n, shdn_n, ax_*) passes a 2-flop synchroniser.
- Clear condition clr = soft_clr | (~eng_mode & ~shdn_n_s).
  - soft_clr is a one-cycle pulse.
  - rst acts as clr plus register reset.
- Filter, per channel: counter cnt[i] (4 bit).
  - Masked input or clr forces cnt = 0.
  - Sampled flt_n low: cnt increments, saturating at FLT_CYC.
  - Sampled flt_n high: cnt = 0.
- Latch: chan_ok[i] <= 0 when cnt reaches FLT_CYC. It remains 0 until clr, with clr dominant in the same cycle.
- First fault: when first_vld = 0 and one or more channels latch in the same cycle, capture the lowest such index and set first_vld. clr clears first_vld and first_id.
- trip = ~(&chan_ok) & ~clr & arm & ~eng_mode & ~soft_block, registered.
- Serial port:
  - Frame active while ax_frame_s = 1.
  - Bit counter bcnt resets to 0 on the rising edge of ax_frame_s.
  - A falling edge of ax_clk_s inside the frame is a bit strobe; bcnt saturates at 63.
- Write frame (ax_write_s = 1): each strobe shifts ax_data_in into shift register sr (MSB first). On the falling edge of ax_frame_s:
  - If bcnt == CW, commit ctrl: mask <= sr[NCH-1:0], soft_block <= sr[NCH], and a one-cycle soft_clr pulse if sr[NCH+1].
  - Otherwise discard the frame; ctrl is unchanged.
- Read frame (ax_write_s = 0): ax_data presents the stream below, one bit per strobe, updated on the strobe:
  - bits 0..7: stat_ok;
  - next NCH bits: chan_ok MSB first;
  - next ID_W bits: first_id MSB first;
  - next bit: first_vld;
  - beyond that: 0.
- Snapshot: status is snapshotted at the frame rising edge so a read frame is self-consistent.

## Timing
- Reset values:
  - chan_ok all 1, stat_ok 1, trip 0, first_vld 0, first_id 0, mux_out 1, ax_data 0.
  - mask 0, soft_block 0, all counters 0.
- Fault latency: flt_n low at the synchroniser input → chan_ok low after 2 + FLT_CYC clk cycles. trip follows one cycle later.
- Glitch rejection: a low pulse shorter than FLT_CYC samples never latches.
- clr deassertion with the fault still present: the fault relatches FLT_CYC cycles later.
- A mask commit takes effect the cycle after the frame-end edge. It does not clear an existing latch.
- ax_clk must be at most clk/4 (high and low phases each ≥ 2 clk cycles).
- rst asserted mid-frame aborts the frame; no commit occurs.

## Structure
- Shared package ovp_pkg holds the read-frame field offsets, the STAT_HDR_LEN = 8 constant, and the ctrl-word bit positions (soft-reset = CW-1, block = CW-2).
- One sub-module, ovp_sync: an N-bit 2-flop synchroniser with async reset and a reset value parameter. It is instantiated for flt_n (reset 1) and for the control lines.
- The remainder (filter/latch array, first-fault encoder, serial FSM IDLE/SHIFT/COMMIT) stays in ovp_fault_ctrl.

## Test plan
- flt_n[5] low for 3 cycles (FLT_CYC = 4) → chan_ok stays all 1. Held low for 10 cycles → chan_ok[5] = 0 at cycle 6, trip = 1 at cycle 7 with arm = 1, first_id = 5.
- flt_n[3] and flt_n[9] fall in the same cycle → first_id = 3. A later flt_n[1] fault leaves first_id = 3.
- Write frame of CW = 26 bits with mask bit 5 set, then flt_n[5] low → no latch. A 25-bit frame → mask unchanged.
- eng_mode = 1 with a fault latched → stat_ok = 1, trip = 0. eng_mode = 0 with shdn_n low → chan_ok returns to all 1 next cycle and first_vld = 0.
- Write frame with the soft-reset bit set while the fault persists → latch clears for one cycle, then relatches after FLT_CYC cycles.
- Read frame after a fault on channel 23 → 8 zeros, then 0 followed by 23 ones, then 10111, then 1, then zeros.

Source files
------------

// File: rtl/ovp_pkg.sv
// ovp_pkg
//   Shared constants for the OVP fault controller: serial FSM state type,
//   read-frame field offsets (in stream order, bit 0 = first bit out) and
//   control-word bit positions.
// Ports: none (package).
package ovp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } ax_state_e;

    // Read frame: status header, then chan_ok, first_id, first_vld.
    localparam int STAT_HDR_LEN = 8;
    localparam int CHAN_OFF     = STAT_HDR_LEN;

    function automatic int id_off(input int nch);
        return STAT_HDR_LEN + nch;
    endfunction

    function automatic int vld_off(input int nch, input int idw);
        return STAT_HDR_LEN + nch + idw;
    endfunction

    function automatic int rd_len(input int nch, input int idw);
        return vld_off(nch, idw) + 1;
    endfunction

    // Control word: [cw-1] soft reset, [cw-2] trip block, [cw-3:0] mask.
    function automatic int ctl_soft_bit(input int cw);
        return cw - 1;
    endfunction

    function automatic int ctl_block_bit(input int cw);
        return cw - 2;
    endfunction

endpackage

// File: rtl/ovp_fault_ctrl_if.sv
// ovp_fault_ctrl_if
//   Serial status/control port from the auxiliary Xilinx.
// Signals:
//   ax_clk      serial bit clock (data strobed on its falling edge)
//   ax_frame    frame enable, active high
//   ax_write    1 = write (control) frame, 0 = read (status) frame
//   ax_data_in  serial write data, MSB first
//   ax_data     serial read data
// Modports: master drives the port, slave is the fault controller.
interface ovp_fault_ctrl_if;
    logic ax_clk;
    logic ax_frame;
    logic ax_write;
    logic ax_data_in;
    logic ax_data;

    modport master (output ax_clk, ax_frame, ax_write, ax_data_in, input ax_data);
    modport slave  (input ax_clk, ax_frame, ax_write, ax_data_in, output ax_data);
endinterface

// File: rtl/ovp_sync.sv
// ovp_sync
//   W-bit two-flop synchroniser with asynchronous active-high reset.
// Parameters: W width, RST_VAL value both flops take in reset.
// Ports:
//   clk, rst  clock / async reset
//   d_i       asynchronous input
//   q_o       synchronised output (two clk cycles of latency)
module ovp_sync #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/ovp_fault_ctrl.sv
// ovp_fault_ctrl
//   Over-voltage protection fault latch: filters NCH active-low fault inputs,
//   latches them per channel under a mask, records the first channel to trip,
//   and drives the shutdown request. A serial port (oversampled in the clk
//   domain) reads a status snapshot and writes the control word.
// Ports:
//   clk, rst    system clock, async active-high reset
//   flt_n       raw active-low fault inputs (async)
//   shdn_n      active-low clear request (async, ignored in eng_mode)
//   eng_mode    engineering mode: stat_ok forced 1, trip suppressed
//   arm         trip enable
//   sel/mux_out readout of chan_ok[sel], 0 when sel >= NCH
//   chan_ok     latched per-channel status (1 = OK)
//   stat_ok     all channels OK, or eng_mode
//   trip        registered shutdown request
//   first_id/first_vld  first latched channel
//   ax          serial status/control port (slave side)
module ovp_fault_ctrl
    import ovp_pkg::*;
#(
    parameter  int NCH     = 24,
    parameter  int FLT_CYC = 4,
    localparam int ID_W    = $clog2(NCH),
    localparam int CW      = NCH + 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  flt_n,
    input  logic            shdn_n,
    input  logic            eng_mode,
    input  logic            arm,
    input  logic [ID_W-1:0] sel,
    output logic            mux_out,
    output logic [NCH-1:0]  chan_ok,
    output logic            stat_ok,
    output logic            trip,
    output logic [ID_W-1:0] first_id,
    output logic            first_vld,
    ovp_fault_ctrl_if.slave ax
);
    localparam int         RD_LEN   = rd_len(NCH, ID_W);
    localparam int         ID_POS   = RD_LEN - 1 - id_off(NCH);
    localparam int         VLD_POS  = RD_LEN - 1 - vld_off(NCH, ID_W);
    localparam int         SOFT_BIT = ctl_soft_bit(CW);
    localparam int         BLK_BIT  = ctl_block_bit(CW);
    localparam int         PAD_W    = 1 << ID_W;
    localparam logic [3:0] FLT_MAX  = 4'(FLT_CYC);

    logic [NCH-1:0] flt_s;
    logic           shdn_n_s, axf_s, axc_s, axw_s, axd_s;

    ovp_sync #(.W(NCH), .RST_VAL({NCH{1'b1}})) u_sync_flt (
        .clk(clk), .rst(rst), .d_i(flt_n), .q_o(flt_s)
    );

    // Frame line resets high so a frame already in progress when reset
    // releases is never seen as a new frame start.
    ovp_sync #(.W(5), .RST_VAL(5'b11000)) u_sync_ctl (
        .clk(clk), .rst(rst),
        .d_i({shdn_n, ax.ax_frame, ax.ax_clk, ax.ax_write, ax.ax_data_in}),
        .q_o({shdn_n_s, axf_s, axc_s, axw_s, axd_s})
    );

    logic [3:0]      cnt_q [NCH];
    logic [3:0]      cnt_d [NCH];
    logic [NCH-1:0]  ok_q, ok_d, mask_q, mask_d;
    logic [ID_W-1:0] fid_q, fid_d;
    logic            fvld_q, fvld_d, trip_q, trip_d, blk_q, blk_d;
    logic            soft_clr, clr, found;
    ax_state_e       st_q, st_d;
    logic [5:0]      bcnt_q, bcnt_d;
    logic            axc_q, axf_q, wr_q, wr_d, axdo_q, axdo_d;
    logic [CW-1:0]   sr_q, sr_d;
    logic [RD_LEN-1:0] snap_q, snap_d, rd_vec;
    logic [PAD_W-1:0]  ok_pad;
    logic            frm_rise, frm_fall, strobe;

    assign clr = soft_clr | (~eng_mode & ~shdn_n_s);

    // Filter / latch / first-fault encoder
    always_comb begin
        ok_d   = ok_q;
        fid_d  = fid_q;
        fvld_d = fvld_q;
        found  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr || mask_q[i] || flt_s[i])
                cnt_d[i] = '0;
            else if (cnt_q[i] != FLT_MAX)
                cnt_d[i] = cnt_q[i] + 4'd1;
            // Latch on the same edge the counter reaches FLT_CYC.
            if (clr) begin
                ok_d[i] = 1'b1;
            end else if (cnt_d[i] == FLT_MAX) begin
                ok_d[i] = 1'b0;
                // Ascending scan: the lowest newly latching index wins.
                if (ok_q[i] && !fvld_q && !found) begin
                    fid_d  = ID_W'(i);
                    fvld_d = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        if (clr) begin
            fid_d  = '0;
            fvld_d = 1'b0;
        end
    end

    assign trip_d = ~(&ok_q) & ~clr & arm & ~eng_mode & ~blk_q;

    // Read-frame image in stream order: rd_vec[RD_LEN-1] goes out first.
    always_comb begin
        rd_vec = '0;
        rd_vec[RD_LEN-1 -: STAT_HDR_LEN]       = {STAT_HDR_LEN{stat_ok}};
        rd_vec[RD_LEN-1-CHAN_OFF -: NCH]       = ok_q;
        rd_vec[ID_POS -: ID_W]                 = fid_q;
        rd_vec[VLD_POS]                        = fvld_q;
    end

    assign frm_rise = axf_s & ~axf_q;
    assign frm_fall = ~axf_s & axf_q;
    assign strobe   = axf_s & axc_q & ~axc_s;

    // Serial port FSM
    always_comb begin
        st_d     = st_q;
        bcnt_d   = bcnt_q;
        wr_d     = wr_q;
        axdo_d   = axdo_q;
        sr_d     = sr_q;
        snap_d   = snap_q;
        mask_d   = mask_q;
        blk_d    = blk_q;
        soft_clr = 1'b0;
        unique case (st_q)
            S_IDLE: begin
                axdo_d = 1'b0;
                if (frm_rise) begin
                    st_d   = S_SHIFT;
                    bcnt_d = '0;
                    wr_d   = axw_s;
                    snap_d = rd_vec;
                end
            end
            S_SHIFT: begin
                if (frm_fall) begin
                    st_d = (wr_q && bcnt_q == 6'(CW)) ? S_COMMIT : S_IDLE;
                end else if (strobe) begin
                    if (bcnt_q != 6'd63)
                        bcnt_d = bcnt_q + 6'd1;
                    if (wr_q) begin
                        sr_d = {sr_q[CW-2:0], axd_s};
                    end else begin
                        axdo_d = snap_q[RD_LEN-1];
                        snap_d = {snap_q[RD_LEN-2:0], 1'b0};
                    end
                end
            end
            S_COMMIT: begin
                mask_d   = sr_q[NCH-1:0];
                blk_d    = sr_q[BLK_BIT];
                soft_clr = sr_q[SOFT_BIT];
                st_d     = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '{default: '0};
            ok_q   <= '1;
            mask_q <= '0;
            fid_q  <= '0;
            fvld_q <= 1'b0;
            trip_q <= 1'b0;
            blk_q  <= 1'b0;
            st_q   <= S_IDLE;
            bcnt_q <= '0;
            wr_q   <= 1'b0;
            axdo_q <= 1'b0;
            axc_q  <= 1'b0;
            axf_q  <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            ok_q   <= ok_d;
            mask_q <= mask_d;
            fid_q  <= fid_d;
            fvld_q <= fvld_d;
            trip_q <= trip_d;
            blk_q  <= blk_d;
            st_q   <= st_d;
            bcnt_q <= bcnt_d;
            wr_q   <= wr_d;
            axdo_q <= axdo_d;
            axc_q  <= axc_s;
            axf_q  <= axf_s;
        end
    end

    always_ff @(posedge clk) begin
        sr_q   <= sr_d;
        snap_q <= snap_d;
    end

    always_comb begin
        ok_pad            = '0;
        ok_pad[NCH-1:0]   = ok_q;
    end

    assign mux_out    = ok_pad[sel];
    assign chan_ok    = ok_q;
    assign stat_ok    = (&ok_q) | eng_mode;
    assign trip       = trip_q;
    assign first_id   = fid_q;
    assign first_vld  = fvld_q;
    assign ax.ax_data = axdo_q;
endmodule
